// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - command-driven initiator for the 8x6-bit register file
module reg_access_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_addr,
    input  logic [5:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [5:0] rsp_data,
    output logic       rsp_flag,
    output logic [2:0] regAddr,
    output logic [5:0] x8,
    output logic       writeReg,
    input  logic [5:0] rf_out
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] op_q;
    logic [5:0] data_q;
    logic [6:0] sum;
    logic [6:0] diff;
    logic       addr_nz;

    // Bit 6 of each 7-bit result is the carry (ADD) or borrow (SUB).
    assign sum     = {1'b0, rf_out} + {1'b0, data_q};
    assign diff    = {1'b0, rf_out} - {1'b0, data_q};
    assign addr_nz = (regAddr != 3'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = EXEC;
            end
            EXEC: state_nxt = (op_q == OP_READ) ? RESP : WR;
            WR:   state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // writeReg is registered and set only on the EXEC->WR edge, so it is a
    // clean one-cycle pulse while regAddr and x8 are already stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= OP_READ;
            data_q   <= 6'd0;
            regAddr  <= 3'd0;
            x8       <= 6'd0;
            writeReg <= 1'b0;
            rsp_data <= 6'd0;
            rsp_flag <= 1'b0;
        end else begin
            writeReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        regAddr <= cmd_addr;
                        data_q  <= cmd_data;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_READ: begin
                            rsp_data <= rf_out;
                            rsp_flag <= 1'b0;
                        end
                        OP_WRITE: begin
                            x8       <= data_q;
                            rsp_flag <= 1'b0;
                            writeReg <= addr_nz;
                        end
                        OP_ADD: begin
                            x8       <= sum[5:0];
                            rsp_flag <= sum[6];
                            writeReg <= addr_nz;
                        end
                        default: begin
                            x8       <= diff[5:0];
                            rsp_flag <= diff[6];
                            writeReg <= addr_nz;
                        end
                    endcase
                end
                WR: begin
                    rsp_data <= addr_nz ? x8 : 6'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - directed self-checking bench for reg_access_ctrl
module tb_reg_access_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_addr;
    logic [5:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_data;
    logic       rsp_flag;
    logic [2:0] regAddr;
    logic [5:0] x8;
    logic       writeReg;
    logic [5:0] rf_out;

    int checks   = 0;
    int failures = 0;

    logic [5:0] rf [8];
    int         pulse_cnt = 0;
    logic [2:0] last_addr;
    logic [5:0] last_data;

    reg_access_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flag  (rsp_flag),
        .regAddr   (regAddr),
        .x8        (x8),
        .writeReg  (writeReg),
        .rf_out    (rf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read, commit on the falling edge.
    assign rf_out = (regAddr == 3'd0) ? 6'd0 : rf[regAddr];

    always @(negedge clk) begin
        if (writeReg === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            last_addr = regAddr;
            last_data = x8;
            if (regAddr != 3'd0) rf[regAddr] = x8;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    // Issue one command (called at #1 after a rising edge, controller idle),
    // report edges from accept to rsp_valid, then take the response.
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [5:0] data,
                          output logic [5:0] d, output logic f, output int lat);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = rsp_data;
        f = rsp_flag;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 8; i++) rf[i] = 6'd0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 3'd0;
        cmd_data = 6'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 3'd6; cmd_data = 6'h11;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_addr  = 3'($urandom_range(0, 7));
        cmd_data  = 6'($urandom_range(0, 63));
        rsp_ready = 1'b0;
        reset     = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_flag, regAddr, x8, writeReg} !== {1'b1, 1'b0, 6'd0, 1'b0, 3'd0, 6'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: got rdy=%b vld=%b data=%h flag=%b addr=%h x8=%h wr=%b need 1 0 00 0 0 00 0",
                     cmd_ready, rsp_valid, rsp_data, rsp_flag, regAddr, x8, writeReg);
        end
        cmd_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_write_read;
        logic [5:0] d; logic f; int lat; int p0;
        p0 = pulse_cnt;
        do_cmd(2'b01, 3'd3, 6'h2A, d, f, lat);
        checks++;
        if (lat !== 2 || d !== 6'h2A || f !== 1'b0) begin
            failures++;
            $display("FAIL write_x3: got lat=%0d data=%h flag=%b need lat=2 data=2a flag=0", lat, d, f);
        end
        checks++;
        if (pulse_cnt - p0 !== 1 || last_addr !== 3'd3 || last_data !== 6'h2A) begin
            failures++;
            $display("FAIL write_pulse: got pulses=%0d addr=%h x8=%h need pulses=1 addr=3 x8=2a",
                     pulse_cnt - p0, last_addr, last_data);
        end
        do_cmd(2'b00, 3'd3, 6'h00, d, f, lat);
        checks++;
        if (lat !== 1 || d !== 6'h2A || f !== 1'b0) begin
            failures++;
            $display("FAIL read_x3: got lat=%0d data=%h flag=%b need lat=1 data=2a flag=0", lat, d, f);
        end
    endtask

    task automatic test_add_carry;
        logic [5:0] d; logic f; int lat;
        do_cmd(2'b01, 3'd5, 6'h3F, d, f, lat);
        do_cmd(2'b10, 3'd5, 6'h02, d, f, lat);
        checks++;
        if (d !== 6'h01 || f !== 1'b1 || rf[5] !== 6'h01) begin
            failures++;
            $display("FAIL add_carry: got data=%h flag=%b x5=%h need data=01 flag=1 x5=01", d, f, rf[5]);
        end
        do_cmd(2'b10, 3'd5, 6'h01, d, f, lat);
        checks++;
        if (d !== 6'h02 || f !== 1'b0 || rf[5] !== 6'h02) begin
            failures++;
            $display("FAIL add_nocarry: got data=%h flag=%b x5=%h need data=02 flag=0 x5=02", d, f, rf[5]);
        end
    endtask

    task automatic test_sub_borrow;
        logic [5:0] d; logic f; int lat;
        do_cmd(2'b01, 3'd2, 6'h04, d, f, lat);
        do_cmd(2'b11, 3'd2, 6'h05, d, f, lat);
        checks++;
        if (d !== 6'h3F || f !== 1'b1 || lat !== 2) begin
            failures++;
            $display("FAIL sub_borrow: got data=%h flag=%b lat=%0d need data=3f flag=1 lat=2", d, f, lat);
        end
        do_cmd(2'b00, 3'd2, 6'h00, d, f, lat);
        checks++;
        if (d !== 6'h3F || f !== 1'b0) begin
            failures++;
            $display("FAIL read_x2: got data=%h flag=%b need data=3f flag=0", d, f);
        end
    endtask

    task automatic test_x0_protect;
        logic [5:0] d; logic f; int lat; int p0;
        p0 = pulse_cnt;
        do_cmd(2'b01, 3'd0, 6'h15, d, f, lat);
        checks++;
        if (d !== 6'h00 || pulse_cnt !== p0) begin
            failures++;
            $display("FAIL write_x0: got data=%h pulses=%0d need data=00 pulses=0", d, pulse_cnt - p0);
        end
        do_cmd(2'b00, 3'd0, 6'h00, d, f, lat);
        checks++;
        if (d !== 6'h00) begin
            failures++;
            $display("FAIL read_x0: got data=%h need data=00", d);
        end
        do_cmd(2'b11, 3'd0, 6'h01, d, f, lat);
        checks++;
        if (d !== 6'h00 || f !== 1'b1 || pulse_cnt !== p0) begin
            failures++;
            $display("FAIL sub_x0: got data=%h flag=%b pulses=%0d need data=00 flag=1 pulses=0",
                     d, f, pulse_cnt - p0);
        end
    endtask

    task automatic test_backpressure;
        logic [5:0] d; logic f; int lat; int bad;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 3'd3; cmd_data = 6'h00;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_op = 2'b01; cmd_addr = 3'd4; cmd_data = 6'h09;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== 6'h2A || cmd_ready !== 1'b0) bad++;
        end
        checks++;
        if (lat !== 1 || bad !== 0) begin
            failures++;
            $display("FAIL hold_resp: got lat=%0d bad_cycles=%0d data=%h rdy=%b need lat=1 bad_cycles=0 data=2a rdy=0",
                     lat, bad, rsp_data, cmd_ready);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL release_resp: got rdy=%b vld=%b need rdy=1 vld=0", cmd_ready, rsp_valid);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || regAddr !== 3'd4) begin
            failures++;
            $display("FAIL accept_next: got rdy=%b addr=%h need rdy=0 addr=4", cmd_ready, regAddr);
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 2 || rsp_data !== 6'h09 || rf[4] !== 6'h09) begin
            failures++;
            $display("FAIL queued_write: got lat=%0d data=%h x4=%h need lat=2 data=09 x4=09", lat, rsp_data, rf[4]);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        // Abort a write by resetting inside WR before the falling edge.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 3'd4; cmd_data = 6'h33;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (writeReg !== 1'b1) begin
            failures++;
            $display("FAIL wr_entered: got writeReg=%b need 1", writeReg);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (writeReg !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_reset_drop: got writeReg=%b rdy=%b need 0 1", writeReg, cmd_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (rf[4] !== 6'h09) begin
            failures++;
            $display("FAIL wr_abort: got x4=%h need x4=09", rf[4]);
        end
        @(posedge clk); #1 reset = 1'b1;
        do_cmd(2'b00, 3'd4, 6'h00, d, f, lat);
        checks++;
        if (d !== 6'h09 || lat !== 1) begin
            failures++;
            $display("FAIL read_after_abort: got data=%h lat=%0d need data=09 lat=1", d, lat);
        end
    endtask

    task automatic test_back_to_back;
        int acc; int p0; logic was_ready;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 3'd2; cmd_data = 6'h00;
        rsp_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            was_ready = cmd_ready;
            @(posedge clk); #1;
            if (was_ready === 1'b1) acc++;
        end
        checks++;
        if (acc !== 3 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_read: got accepts=%0d rdy=%b need accepts=3 rdy=1", acc, cmd_ready);
        end
        p0 = pulse_cnt;
        cmd_op = 2'b01; cmd_addr = 3'd1; cmd_data = 6'h27;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            was_ready = cmd_ready;
            @(posedge clk); #1;
            if (was_ready === 1'b1) acc++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (acc !== 3 || pulse_cnt - p0 !== 3 || cmd_ready !== 1'b1 || rf[1] !== 6'h27) begin
            failures++;
            $display("FAIL b2b_write: got accepts=%0d pulses=%0d rdy=%b x1=%h need accepts=3 pulses=3 rdy=1 x1=27",
                     acc, pulse_cnt - p0, cmd_ready, rf[1]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_add_carry();
        test_sub_borrow();
        test_x0_protect();
        test_backpressure();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
